ov7670_frame_capture: RTL
=========================

Name: ov7670_frame_capture

Overview:
- Parametrised capture engine for OV7670-class parallel cameras.
- Samples PCLK/HREF/VSYNC/data in the system clock domain and assembles 1- or 2-byte pixels.
- Issues linear frame-buffer writes from a programmable base address, with frame bookkeeping and error flags.
- Sits between the camera pins and the frame-buffer write port; the sensor is configured over SCCB elsewhere.

Parameters:
- PIX_WIDTH, 8, camera data bus width (8 or 10).
- BYTES_PER_PIXEL, 2, bus samples per pixel (1 = raw/Y, 2 = RGB565/YUV pair).
- DWIDTH, 16, write-data width.
- AWIDTH, 32, write-address width.
- H_ACTIVE, 640, pixels accepted per line.
- V_ACTIVE, 480, lines accepted per frame.

Ports:
- clk  input  1  system clock; must be at least 4x PCLK.
- rst  input  1  asynchronous active-high reset.
- enable  input  1  arm capture; low returns the block to IDLE at the next frame boundary.
- single_shot  input  1  1 = stop after one frame; 0 = continuous.
- base_addr  input  AWIDTH  frame-buffer base; latched at frame start.
- cam_pclk  input  1  camera pixel clock, treated as data.
- cam_href  input  1  line valid.
- cam_vsync  input  1  frame sync, high between frames.
- cam_data  input  PIX_WIDTH  camera data.
- wr_en  output  1  one-cycle write strobe.
- wr_addr  output  AWIDTH  write address.
- wr_data  output  DWIDTH  assembled pixel.
- busy  output  1  high in states WAIT_VSYNC and CAPTURE.
- frame_done  output  1  one-cycle pulse at end of frame.
- line_overflow  output  1  sticky: a line exceeded H_ACTIVE or the frame exceeded V_ACTIVE.
- short_frame  output  1  sticky: a frame ended with fewer than V_ACTIVE lines.
- frame_count  output  16  completed frames, wraps 0xFFFF -> 0.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Input synchronisation:
  - cam_pclk, cam_href, cam_vsync and cam_data each pass through 2 flops, then 1 edge-detect register.
  - A sample event is a synced PCLK rising edge while synced HREF = 1.
  - The data used is the synced value aligned with that edge.
- Byte assembly:
  - The byte phase clears on each synced HREF rise.
  - With BYTES_PER_PIXEL = 2, the first byte is the MSB part: wr_data = {b0, b1} zero-extended or LSB-truncated to DWIDTH.
  - With BYTES_PER_PIXEL = 1, wr_data = b0 zero-extended.
  - A pixel left incomplete at HREF fall is discarded silently.
- Latency: wr_en asserts on the 4th clk edge after the clk edge that first samples the completing cam_pclk high.
- wr_addr = base_latched + line_idx*H_ACTIVE + pix_idx.
- States:
  - IDLE: enable = 1 -> WAIT_VSYNC.
  - WAIT_VSYNC: waits for a synced VSYNC falling edge. There it latches base_addr, clears line_idx and pix_idx, and moves to CAPTURE. enable = 0 -> IDLE.
  - CAPTURE: writes pixels.
    - HREF fall increments line_idx and clears pix_idx.
    - If pix_idx = H_ACTIVE when a new pixel completes: the write is suppressed and line_overflow is set.
    - Lines with line_idx >= V_ACTIVE are suppressed and set line_overflow.
    - VSYNC rise pulses frame_done, increments frame_count, and sets short_frame if line_idx < V_ACTIVE.
    - Exit from CAPTURE: if single_shot = 1 or enable = 0 -> IDLE; else -> WAIT_VSYNC.
- The sticky flags clear only on rst or on the IDLE -> WAIT_VSYNC transition.
- Dropping enable mid-frame does not abort; the frame completes.
- rst mid-frame: immediate return to IDLE with all outputs 0, and no partial frame_done.
- If VSYNC rises in the same cycle as a pixel completes: the pixel is written first, and frame_done coincides with or follows that write.

Optional Feature:
- OV7670_CAPTURE_DECIMATE_EN
- Defined:
  - Adds input decim (1 bit).
  - When decim = 1: only even pixels of even lines are written. The address stride becomes H_ACTIVE/2 per line. Limits become H_ACTIVE/2 x V_ACTIVE/2 for the overflow and short_frame checks.
  - decim is latched at frame start.
- Undefined: no port is added, and every pixel is written.

Test Plan:
- Single-shot 4x2 frame (H_ACTIVE = 4, V_ACTIVE = 2, 2 bytes/pixel), base 0x1000, bytes 0x11..0x20 -> 8 writes at 0x1000..0x1007, first data 0x1112, then frame_done pulse, frame_count = 1, state IDLE, busy = 0.
- Continuous mode, 3 frames -> frame_count = 3, addresses restart at base each frame, and each write is 4 clk after the PCLK sample.
- Line with 5 pixels, H_ACTIVE = 4 -> 4 writes, 5th suppressed, line_overflow = 1 and sticky until re-arm.
- VSYNC rises after 1 of 2 lines -> frame_done pulses, short_frame = 1; 3 bytes on a line -> 1 pixel written, odd byte dropped.
- rst asserted mid-line -> outputs 0 immediately; re-enable -> a clean capture starting at base_addr.
- With OV7670_CAPTURE_DECIMATE_EN, decim = 1, 8x4 frame -> 8 writes at base+0..7, pixels 0, 2, 4, 6 of lines 0 and 2.

Source files
------------

// File: rtl/ov7670_frame_capture_if.sv
// Camera pin bundle plus frame-buffer write port for ov7670_frame_capture.
// The master modport is the capture engine; the slave side is the sensor/memory environment.
interface ov7670_frame_capture_if #(
    parameter int unsigned PIX_WIDTH = 8,
    parameter int unsigned DWIDTH    = 16,
    parameter int unsigned AWIDTH    = 32
);
    logic                 cam_pclk;
    logic                 cam_href;
    logic                 cam_vsync;
    logic [PIX_WIDTH-1:0] cam_data;
    logic                 wr_en;
    logic [AWIDTH-1:0]    wr_addr;
    logic [DWIDTH-1:0]    wr_data;

    modport master (
        input  cam_pclk, cam_href, cam_vsync, cam_data,
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        output cam_pclk, cam_href, cam_vsync, cam_data,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/ov7670_frame_capture.sv
// OV7670-class parallel camera capture into a linear frame buffer.
// Optional OV7670_CAPTURE_DECIMATE_EN adds a 'decim' input for 2:1 decimation in both axes.
module ov7670_frame_capture #(
    parameter int unsigned PIX_WIDTH       = 8,
    parameter int unsigned BYTES_PER_PIXEL = 2,
    parameter int unsigned DWIDTH          = 16,
    parameter int unsigned AWIDTH          = 32,
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned V_ACTIVE        = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  single_shot,
    input  logic [AWIDTH-1:0]     base_addr,
`ifdef OV7670_CAPTURE_DECIMATE_EN
    input  logic                  decim,
`endif
    ov7670_frame_capture_if.master bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  line_overflow,
    output logic                  short_frame,
    output logic [15:0]           frame_count
);

    localparam int unsigned RAW_W = BYTES_PER_PIXEL * PIX_WIDTH;
    localparam int unsigned CW    = 16;
    localparam logic [CW-1:0] H_LIM  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_LIM  = CW'(V_ACTIVE);

    typedef enum logic [1:0] {StIdle, StWaitVsync, StCapture} state_t;

    state_t state_q, state_d;

    // Two-flop synchronisers followed by one edge-detect register.
    logic                 pclk_s1, pclk_s2, pclk_d;
    logic                 href_s1, href_s2, href_d;
    logic                 vs_s1, vs_s2, vs_d;
    logic [PIX_WIDTH-1:0] data_s1, data_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {pclk_s1, pclk_s2, pclk_d} <= '0;
            {href_s1, href_s2, href_d} <= '0;
            {vs_s1, vs_s2, vs_d}       <= '0;
            data_s1                    <= '0;
            data_s2                    <= '0;
        end else begin
            pclk_s1 <= bus.cam_pclk;
            pclk_s2 <= pclk_s1;
            pclk_d  <= pclk_s2;
            href_s1 <= bus.cam_href;
            href_s2 <= href_s1;
            href_d  <= href_s2;
            vs_s1   <= bus.cam_vsync;
            vs_s2   <= vs_s1;
            vs_d    <= vs_s2;
            data_s1 <= bus.cam_data;
            data_s2 <= data_s1;
        end
    end

    logic sample, href_rise, href_fall, vs_rise, vs_fall;
    assign sample    = pclk_s2 & ~pclk_d & href_s2;
    assign href_rise = href_s2 & ~href_d;
    assign href_fall = ~href_s2 & href_d;
    assign vs_rise   = vs_s2 & ~vs_d;
    assign vs_fall   = ~vs_s2 & vs_d;

    // Stage 1: byte assembly; line/frame events are delayed to stay in step with pixels.
    logic                 phase_q, phase_eff;
    logic [PIX_WIDTH-1:0] first_q;
    logic [RAW_W-1:0]     raw, pix_raw_q;
    logic                 pix_done_q, href_fall_q, vs_rise_q, vs_fall_q;

    assign phase_eff = href_rise ? 1'b0 : phase_q;

    if (BYTES_PER_PIXEL == 2) begin : g_two_bytes
        assign raw = {first_q, data_s2};
    end else begin : g_one_byte
        assign raw = data_s2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= 1'b0;
            first_q     <= '0;
            pix_raw_q   <= '0;
            pix_done_q  <= 1'b0;
            href_fall_q <= 1'b0;
            vs_rise_q   <= 1'b0;
            vs_fall_q   <= 1'b0;
        end else begin
            pix_done_q  <= 1'b0;
            href_fall_q <= href_fall;
            vs_rise_q   <= vs_rise;
            vs_fall_q   <= vs_fall;
            if (href_rise) phase_q <= 1'b0;
            if (sample) begin
                if (BYTES_PER_PIXEL == 1 || phase_eff) begin
                    pix_done_q <= 1'b1;
                    pix_raw_q  <= raw;
                    phase_q    <= 1'b0;
                end else begin
                    first_q <= data_s2;
                    phase_q <= 1'b1;
                end
            end
        end
    end

    logic [DWIDTH-1:0] pix_data;
    if (DWIDTH >= RAW_W) begin : g_zero_ext
        assign pix_data = DWIDTH'(pix_raw_q);
    end else begin : g_trunc
        assign pix_data = pix_raw_q[RAW_W-1 -: DWIDTH];
    end

    // FSM: state register / next state / outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (enable) state_d = StWaitVsync;
            StWaitVsync: begin
                if (!enable)        state_d = StIdle;
                else if (vs_fall_q) state_d = StCapture;
            end
            StCapture:   if (vs_rise_q) state_d = (single_shot || !enable) ? StIdle : StWaitVsync;
            default:     state_d = StIdle;
        endcase
    end

    logic arm, start, capturing;
    always_comb begin
        busy      = (state_q == StWaitVsync) || (state_q == StCapture);
        arm       = (state_q == StIdle) && (state_d == StWaitVsync);
        start     = (state_q == StWaitVsync) && (state_d == StCapture);
        capturing = (state_q == StCapture);
    end

    // Stage 2: placement, limits and address generation.
    logic [AWIDTH-1:0] base_q, offset, stride;
    logic [CW-1:0]     pix_idx, line_idx, eff_pix, eff_line, lines_seen, h_lim, v_lim;
    logic              keep, overflow_hit;
`ifdef OV7670_CAPTURE_DECIMATE_EN
    logic              decim_q;
`endif

    always_comb begin
        h_lim      = H_LIM;
        v_lim      = V_LIM;
        stride     = AWIDTH'(H_ACTIVE);
        eff_pix    = pix_idx;
        eff_line   = line_idx;
        lines_seen = line_idx;
        keep       = 1'b1;
`ifdef OV7670_CAPTURE_DECIMATE_EN
        if (decim_q) begin
            h_lim      = CW'(H_ACTIVE / 2);
            v_lim      = CW'(V_ACTIVE / 2);
            stride     = AWIDTH'(H_ACTIVE / 2);
            eff_pix    = pix_idx >> 1;
            eff_line   = line_idx >> 1;
            lines_seen = (line_idx + 16'd1) >> 1;
            keep       = ~pix_idx[0] & ~line_idx[0];
        end
`endif
        overflow_hit = (eff_pix >= h_lim) || (eff_line >= v_lim);
        offset       = AWIDTH'(eff_line) * stride + AWIDTH'(eff_pix);
    end

    logic              wr_pend_q, fd_pend_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q        <= '0;
            pix_idx       <= '0;
            line_idx      <= '0;
            wr_pend_q     <= 1'b0;
            fd_pend_q     <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            line_overflow <= 1'b0;
            short_frame   <= 1'b0;
`ifdef OV7670_CAPTURE_DECIMATE_EN
            decim_q       <= 1'b0;
`endif
        end else begin
            wr_pend_q <= 1'b0;
            fd_pend_q <= 1'b0;
            if (arm) begin
                line_overflow <= 1'b0;
                short_frame   <= 1'b0;
            end
            if (start) begin
                base_q   <= base_addr;
                pix_idx  <= '0;
                line_idx <= '0;
`ifdef OV7670_CAPTURE_DECIMATE_EN
                decim_q  <= decim;
`endif
            end
            if (capturing) begin
                if (pix_done_q) begin
                    if (overflow_hit) begin
                        line_overflow <= 1'b1;
                    end else if (keep) begin
                        wr_pend_q <= 1'b1;
                        addr_q    <= base_q + offset;
                        data_q    <= pix_data;
                    end
                    // Saturate so runaway lines keep reporting overflow instead of wrapping.
                    if (pix_idx < H_LIM) pix_idx <= pix_idx + 16'd1;
                end
                if (href_fall_q) begin
                    pix_idx <= '0;
                    if (line_idx < V_LIM) line_idx <= line_idx + 16'd1;
                end
                if (vs_rise_q) begin
                    fd_pend_q <= 1'b1;
                    if (lines_seen < v_lim) short_frame <= 1'b1;
                end
            end
        end
    end

    // Stage 3: outputs; frame_done shares this stage so it never precedes a final write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            bus.wr_en  <= wr_pend_q;
            frame_done <= fd_pend_q;
            if (wr_pend_q) begin
                bus.wr_addr <= addr_q;
                bus.wr_data <= data_q;
            end
            if (fd_pend_q) frame_count <= frame_count + 16'd1;
        end
    end

endmodule
